// File: rtl/iic_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iic_slave_if : register-side bus between the I2C target and its regfile  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface iic_slave_if;
  logic [15:0] reg_addr;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_data;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_data;

  modport slave (
    output reg_addr,
    output reg_wr_en,
    output reg_wr_data,
    output reg_rd_en,
    input  reg_rd_data
  );

  modport master (
    input  reg_addr,
    input  reg_wr_en,
    input  reg_wr_data,
    input  reg_rd_en,
    output reg_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/iic_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iic_slave : oversampled I2C target with 8/16-bit register addressing;    |
// | IIC_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter. Rev 1.0      |
// +--------------------------------------------------------------------------+
module iic_slave #(
  parameter logic [6:0] DEVICE_ADDR = 7'b1111_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       addr_num,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  iic_slave_if.slave rbus,
  output logic       busy,
  output logic       xfer_end
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV_ADDR  = 4'd1,
    ACK_DEV   = 4'd2,
    ADDR_H    = 4'd3,
    ACK_AH    = 4'd4,
    ADDR_L    = 4'd5,
    ACK_AL    = 4'd6,
    WR_BYTE   = 4'd7,
    ACK_WR    = 4'd8,
    RD_BYTE   = 4'd9,
    MACK      = 4'd10,
    WAIT_STOP = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_en_q, rd_en_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        xfer_end_q, xfer_end_d;
  logic        rw_q, rw_d;
  logic        mack_q, mack_d;

  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic        w_scl, w_sda;
  logic        w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [15:0] w_addr_inc;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda};
    end
  end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
    end
  end

  // A single-sample pulse never wins the vote, so it is rejected outright.
  assign w_scl = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                 (scl_hist_q[1] & scl_hist_q[2]);
  assign w_sda = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                 (sda_hist_q[1] & sda_hist_q[2]);
`else
  assign w_scl = scl_sync_q[1];
  assign w_sda = sda_sync_q[1];
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= w_scl;
      sda_prev_q <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~scl_prev_q;
  assign w_scl_fall = ~w_scl & scl_prev_q;
  assign w_start    = scl_prev_q & w_scl & sda_prev_q & ~w_sda;
  assign w_stop     = scl_prev_q & w_scl & ~sda_prev_q & w_sda;

  // One-byte mode keeps the upper address byte at zero and wraps at 8 bits.
  assign w_addr_inc = addr_num ? (addr_q + 16'd1) : {8'h00, addr_q[7:0] + 8'd1};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    addr_d     = addr_q;
    addr_hi_d  = addr_hi_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    oe_d       = oe_q;
    busy_d     = busy_q;
    xfer_end_d = 1'b0;
    rw_d       = rw_q;
    mack_d     = mack_q;

    case (state_q)
      DEV_ADDR, ADDR_H, ADDR_L, WR_BYTE: begin
        if (w_scl_rise && (cnt_q < 4'd8)) begin
          sh_d  = {sh_q[6:0], w_sda};
          cnt_d = cnt_q + 4'd1;
        end else if (w_scl_fall && (cnt_q == 4'd8)) begin
          cnt_d = 4'd0;
          if (state_q == DEV_ADDR) begin
            if (sh_q[7:1] == DEVICE_ADDR) begin
              state_d = ACK_DEV;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = sh_q[0];
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (state_q == ADDR_H) begin
            state_d   = ACK_AH;
            oe_d      = 1'b1;
            addr_hi_d = sh_q;
          end else if (state_q == ADDR_L) begin
            state_d = ACK_AL;
            oe_d    = 1'b1;
          end else begin
            state_d   = ACK_WR;
            oe_d      = 1'b1;
            wr_en_d   = 1'b1;
            wr_data_d = sh_q;
          end
        end
      end

      ACK_DEV: begin
        if (w_scl_fall) begin
          oe_d  = 1'b0;
          cnt_d = 4'd0;
          if (rw_q) begin
            state_d = RD_BYTE;
            rd_en_d = 1'b1;
          end else begin
            state_d = addr_num ? ADDR_H : ADDR_L;
          end
        end
      end

      ACK_AH: begin
        if (w_scl_fall) begin
          oe_d    = 1'b0;
          state_d = ADDR_L;
        end
      end

      ACK_AL: begin
        if (w_scl_fall) begin
          oe_d    = 1'b0;
          state_d = WR_BYTE;
          addr_d  = addr_num ? {addr_hi_q, sh_q} : {8'h00, sh_q};
        end
      end

      ACK_WR: begin
        if (w_scl_fall) begin
          oe_d    = 1'b0;
          state_d = WR_BYTE;
          addr_d  = w_addr_inc;
        end
      end

      RD_BYTE: begin
        // Read data arrives the cycle after the request; MSB goes out at once.
        if (rd_en_q) begin
          sh_d = rbus.reg_rd_data;
          oe_d = ~rbus.reg_rd_data[7];
        end else if (w_scl_rise && (cnt_q < 4'd8)) begin
          cnt_d = cnt_q + 4'd1;
        end else if (w_scl_fall) begin
          if (cnt_q == 4'd8) begin
            state_d = MACK;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
          end else if (cnt_q != 4'd0) begin
            sh_d = {sh_q[6:0], 1'b0};
            oe_d = ~sh_q[6];
          end
        end
      end

      MACK: begin
        if (w_scl_rise) begin
          mack_d = w_sda;
          if (!w_sda) addr_d = w_addr_inc;
        end else if (w_scl_fall) begin
          if (!mack_q) begin
            state_d = RD_BYTE;
            rd_en_d = 1'b1;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT_STOP;
          end
        end
      end

      IDLE, WAIT_STOP: ;

      default: state_d = IDLE;
    endcase

    if (w_stop) begin
      state_d    = IDLE;
      oe_d       = 1'b0;
      busy_d     = 1'b0;
      xfer_end_d = busy_q;
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
    end

    if (w_start) begin
      state_d = DEV_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 8'h00;
      addr_q     <= 16'h0000;
      addr_hi_q  <= 8'h00;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      rd_en_q    <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      xfer_end_q <= 1'b0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      addr_hi_q  <= addr_hi_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      xfer_end_q <= xfer_end_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
    end
  end

  assign i2c_sda          = oe_q ? 1'b0 : 1'bz;
  assign rbus.reg_addr    = addr_q;
  assign rbus.reg_wr_en   = wr_en_q;
  assign rbus.reg_wr_data = wr_data_q;
  assign rbus.reg_rd_en   = rd_en_q;
  assign busy             = busy_q;
  assign xfer_end         = xfer_end_q;

endmodule
`default_nettype wire
